serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 32 +++
 rtl/serial_addsub.sv | 118 +++++++++++
 tb/tb_serial_addsub.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
//------------------------------------------------------------------------------
// serial_addsub_if
// Operand/request and result bundle for the bit-serial adder/subtractor.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_addsub.sv
//------------------------------------------------------------------------------
// serial_addsub
// Bit-serial add/subtract, LSB first, one full-adder cell per clock.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int c_cntw = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [c_cntw-1:0] c_last = c_cntw'(WIDTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic              r_c;
  logic [WIDTH-1:0]  r_acc;
  logic [c_cntw-1:0] r_cnt;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic              w_accept;
  logic              w_last;
  logic              w_s;
  logic              w_cnext;
  logic [WIDTH-1:0]  w_acc_next;
  logic              w_busy;
  logic              w_done;

  assign w_accept = bus.start && (r_state != c_run);
  assign w_last   = (r_cnt == c_last);

  // One full-adder cell; its carry lives in r_c between bits.
  assign w_s     = r_x[0] ^ r_y[0] ^ r_c;
  assign w_cnext = (r_x[0] & r_y[0]) | (r_x[0] & r_c) | (r_y[0] & r_c);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_acc_next = w_s;
    end else begin : g_wn
      assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (bus.start) w_state_next = c_run;
      c_run:   if (w_last) w_state_next = c_done;
      c_done:  w_state_next = bus.start ? c_run : c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_run);
    w_done = (r_state == c_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1: invert B once here and seed the carry.
      r_x   <= bus.a;
      r_y   <= bus.b ^ {WIDTH{bus.sub}};
      r_c   <= bus.sub;
      r_cnt <= '0;
    end else if (r_state == c_run) begin
      r_x   <= r_x >> 1;
      r_y   <= r_y >> 1;
      r_c   <= w_cnext;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + c_cntw'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_cnext;
        r_ovf  <= r_c ^ w_cnext;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
//------------------------------------------------------------------------------
// tb_serial_addsub
// Directed bench for serial_addsub at WIDTH = 8 and WIDTH = 1.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(1)) bus1 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Drives one operation and measures edges from accept to done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       output int lat, output bit busy_ok, output bit stable);
    logic [7:0] prev;
    prev = bus8.sum;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0; busy_ok = 1'b1; stable = 1'b1;
    while (lat < 20 && !bus8.done) begin
      if (bus8.busy !== 1'b1) busy_ok = 1'b0;
      if (bus8.sum !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus8.busy); end
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus8.done); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== 10'h0) begin n_err++;
      $display("FAIL reset_result: got sum=%h cout=%b ovf=%b expected all 0", bus8.sum, bus8.cout, bus8.overflow); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat; bit bok, stb;
    do_op(8'h05, 8'h03, 1'b0, lat, bok, stb);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL add_latency: got %0d expected 8", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL add_busy_run: got %b expected 1", bok); end
    n_cmp++; if (stb !== 1'b1) begin n_err++; $display("FAIL add_sum_stable: got %b expected 1", stb); end
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL add_busy_done: got %b expected 0", bus8.busy); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h08, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL add_result: got %h/%b/%b expected 08/0/0", bus8.sum, bus8.cout, bus8.overflow); end
    @(posedge clk); #1;
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b expected 0", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'h08) begin n_err++; $display("FAIL add_hold: got %h expected 08", bus8.sum); end
  endtask

  task automatic test_overflow;
    int lat; bit bok, stb;
    do_op(8'hFF, 8'h01, 1'b0, lat, bok, stb);
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h00, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL carry_ff01: got %h/%b/%b expected 00/1/0", bus8.sum, bus8.cout, bus8.overflow); end
    do_op(8'h7F, 8'h01, 1'b0, lat, bok, stb);
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h80, 1'b0, 1'b1}) begin n_err++;
      $display("FAIL ovf_7f01: got %h/%b/%b expected 80/0/1", bus8.sum, bus8.cout, bus8.overflow); end
  endtask

  task automatic test_sub;
    int lat; bit bok, stb;
    do_op(8'h03, 8'h05, 1'b1, lat, bok, stb);
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'hFE, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL sub_0305: got %h/%b/%b expected FE/0/0", bus8.sum, bus8.cout, bus8.overflow); end
    do_op(8'h80, 8'h01, 1'b1, lat, bok, stb);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL sub_latency: got %0d expected 8", lat); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h7F, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL sub_8001: got %h/%b/%b expected 7F/1/1", bus8.sum, bus8.cout, bus8.overflow); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    bus8.a = 8'h05; bus8.b = 8'h03; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (lat < 20 && !bus8.done) begin
      if (lat == 3) begin
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.sub = 1'b1; bus8.start = 1'b1;
      end
      if (lat == 5) bus8.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h08, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL ignore_result: got %h/%b/%b expected 08/0/0", bus8.sum, bus8.cout, bus8.overflow); end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok, stb;
    do_op(8'h12, 8'h34, 1'b0, lat, bok, stb);
    n_cmp++; if ({bus8.done, bus8.sum} !== {1'b1, 8'h46}) begin n_err++;
      $display("FAIL b2b_first: got done=%b sum=%h expected 1/46", bus8.done, bus8.sum); end
    // Still in the DONE cycle: request the next operation immediately.
    bus8.a = 8'h50; bus8.b = 8'h10; bus8.sub = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n_cmp++; if ({bus8.busy, bus8.done} !== 2'b10) begin n_err++;
      $display("FAIL b2b_no_idle: got busy/done=%b%b expected 10", bus8.busy, bus8.done); end
    lat = 0;
    while (lat < 20 && !bus8.done) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h40, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL b2b_second: got %h/%b/%b expected 40/1/0", bus8.sum, bus8.cout, bus8.overflow); end
  endtask

  task automatic test_async_reset;
    int lat; bit bok, stb, saw_done;
    do_op(8'h7F, 8'h01, 1'b0, lat, bok, stb);
    @(negedge clk);
    bus8.a = 8'h55; bus8.b = 8'h0F; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({bus8.busy, bus8.done} !== 2'b00) begin n_err++;
      $display("FAIL arst_ctrl: got busy/done=%b%b expected 00", bus8.busy, bus8.done); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== 10'h0) begin n_err++;
      $display("FAIL arst_result: got %h/%b/%b expected 00/0/0", bus8.sum, bus8.cout, bus8.overflow); end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus8.done) saw_done = 1'b1;
    end
    @(negedge clk) rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus8.done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL arst_no_done: got %b expected 0", saw_done); end
    do_op(8'h10, 8'h20, 1'b0, lat, bok, stb);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL arst_after_latency: got %0d expected 8", lat); end
    n_cmp++; if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h30, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL arst_after_result: got %h/%b/%b expected 30/0/0", bus8.sum, bus8.cout, bus8.overflow); end
  endtask

  task automatic test_width1;
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    logic [2:0] idx;
    // Index is {sub, a, b}; tables hand-derived from A + (B ^ sub) + sub.
    sum_tab  = 8'h66;
    cout_tab = 8'hD8;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      bus1.sub = idx[2]; bus1.a = idx[1]; bus1.b = idx[0]; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      n_cmp++; if (bus1.busy !== 1'b1) begin n_err++; $display("FAIL w1_busy[%0d]: got %b expected 1", i, bus1.busy); end
      @(posedge clk); #1;
      n_cmp++; if (bus1.done !== 1'b1) begin n_err++; $display("FAIL w1_done[%0d]: got %b expected 1", i, bus1.done); end
      n_cmp++; if ({bus1.sum, bus1.cout} !== {sum_tab[i], cout_tab[i]}) begin n_err++;
        $display("FAIL w1_result[%0d]: got %b/%b expected %b/%b", i, bus1.sum, bus1.cout, sum_tab[i], cout_tab[i]); end
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
